// File: rtl/cpu_loader_pkg.sv
// Shared constants and state encoding for the host-side program/data loader.
package cpu_loader_pkg;

  localparam logic [7:0] OP_LOAD_I    = 8'h01;
  localparam logic [7:0] OP_LOAD_D    = 8'h02;
  localparam logic [7:0] OP_RUN       = 8'h03;
  localparam logic [7:0] OP_DUMP_D    = 8'h04;
  localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_CNT,
    S_GET_DATA,
    S_WRITE,
    S_RUN,
    S_RD_REQ,
    S_RD_WAIT,
    S_SEND,
    S_ACK
  } state_e;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_LOAD_I) || (op == OP_LOAD_D) || (op == OP_RUN) || (op == OP_DUMP_D);
  endfunction

endpackage

// File: rtl/loader_shift_reg.sv
// 64-bit byte shifter: serial-in LSB-first for incoming fields/words,
// parallel-load then serial-out LSB-first for dumps.
module loader_shift_reg (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        clr,
  input  logic        shift_in,
  input  logic [7:0]  din,
  input  logic        load,
  input  logic [63:0] pdata,
  input  logic        shift_out,
  output logic [63:0] q,
  output logic [2:0]  bcnt
);

  // New bytes enter at the top, so after k bytes the field sits in the top k bytes.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q    <= '0;
      bcnt <= '0;
    end else if (clr) begin
      q    <= '0;
      bcnt <= '0;
    end else if (load) begin
      q    <= pdata;
      bcnt <= '0;
    end else if (shift_in) begin
      q    <= {din, q[63:8]};
      bcnt <= bcnt + 3'd1;
    end else if (shift_out) begin
      q    <= {8'h00, q[63:8]};
      bcnt <= bcnt + 3'd1;
    end
  end

endmodule

// File: rtl/cpu_host_loader.sv
// Byte-stream command engine that loads instruction/data memories, runs the
// core for a fixed cycle count, and dumps data memory back out.
module cpu_host_loader
  import cpu_loader_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter int         RUN_W    = 32,
  parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [7:0]  m_data,
  input  logic        m_ready,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy,
  output logic        err
);

  state_e           state, state_nx;
  logic [7:0]       op;
  logic [CNT_W-1:0] cnt, idx;
  logic [RUN_W-1:0] run_cnt;

  logic [63:0] sr_q;
  logic [2:0]  sr_bcnt;
  logic        sr_clr, sr_shift_in, sr_load, sr_shift_out;

  logic             acc, fld_last, word_last, last_idx;
  logic [CNT_W-1:0] cnt_fld;
  logic [RUN_W-1:0] run_fld;
  logic             op_ld, err_set, cnt_ld, run_ld, run_dec, idx_inc;

  logic unused_rdata;
  assign unused_rdata = ^rdata_ext;

  assign acc       = s_valid && s_ready;
  // Completed fields are assembled from the held bytes plus the byte on the bus.
  assign cnt_fld   = CNT_W'({s_data, sr_q[63:56]});
  assign run_fld   = RUN_W'({s_data, sr_q[63:40]});
  assign fld_last  = (sr_bcnt == ((op == OP_RUN) ? 3'd3 : 3'd1));
  assign word_last = (sr_bcnt == ((op == OP_LOAD_I) ? 3'd3 : 3'd7));
  assign last_idx  = (idx == cnt - CNT_W'(1));

  loader_shift_reg u_sr (
    .clk       (clk),
    .arst_n    (arst_n),
    .clr       (sr_clr),
    .shift_in  (sr_shift_in),
    .din       (s_data),
    .load      (sr_load),
    .pdata     (rdata_ext_2),
    .shift_out (sr_shift_out),
    .q         (sr_q),
    .bcnt      (sr_bcnt)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    m_data       = 8'h00;
    cpu_enable   = 1'b0;
    wen_ext      = 1'b0;
    wen_ext_2    = 1'b0;
    ren_ext_2    = 1'b0;
    sr_clr       = 1'b0;
    sr_shift_in  = 1'b0;
    sr_load      = 1'b0;
    sr_shift_out = 1'b0;
    op_ld        = 1'b0;
    err_set      = 1'b0;
    cnt_ld       = 1'b0;
    run_ld       = 1'b0;
    run_dec      = 1'b0;
    idx_inc      = 1'b0;
    case (state)
      S_IDLE: begin
        s_ready = 1'b1;
        sr_clr  = 1'b1;
        if (acc) begin
          if (op_known(s_data)) begin
            op_ld    = 1'b1;
            state_nx = S_GET_CNT;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_GET_CNT: begin
        s_ready = 1'b1;
        if (acc) begin
          if (fld_last) begin
            sr_clr = 1'b1;
            if (op == OP_RUN) begin
              run_ld   = 1'b1;
              state_nx = (run_fld == '0) ? S_ACK : S_RUN;
            end else begin
              cnt_ld = 1'b1;
              if (cnt_fld == '0)        state_nx = S_ACK;
              else if (op == OP_DUMP_D) state_nx = S_RD_REQ;
              else                      state_nx = S_GET_DATA;
            end
          end else begin
            sr_shift_in = 1'b1;
          end
        end
      end
      S_GET_DATA: begin
        s_ready = 1'b1;
        if (acc) begin
          sr_shift_in = 1'b1;
          if (word_last) state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        wen_ext   = (op == OP_LOAD_I);
        wen_ext_2 = (op == OP_LOAD_D);
        sr_clr    = 1'b1;
        idx_inc   = 1'b1;
        state_nx  = last_idx ? S_ACK : S_GET_DATA;
      end
      S_RUN: begin
        cpu_enable = 1'b1;
        run_dec    = 1'b1;
        if (run_cnt == RUN_W'(1)) state_nx = S_ACK;
      end
      S_RD_REQ: begin
        ren_ext_2 = 1'b1;
        state_nx  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        sr_load  = 1'b1;
        state_nx = S_SEND;
      end
      S_SEND: begin
        m_valid = 1'b1;
        m_data  = sr_q[7:0];
        if (m_ready) begin
          sr_shift_out = 1'b1;
          if (sr_bcnt == 3'd7) begin
            idx_inc  = 1'b1;
            state_nx = last_idx ? S_ACK : S_RD_REQ;
          end
        end
      end
      S_ACK: begin
        m_valid = 1'b1;
        m_data  = ACK_BYTE;
        if (m_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      op      <= 8'h00;
      cnt     <= '0;
      idx     <= '0;
      run_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (op_ld)   op  <= s_data;
      if (err_set) err <= 1'b1;
      if (cnt_ld) begin
        cnt <= cnt_fld;
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + CNT_W'(1);
      end
      if (run_ld)       run_cnt <= run_fld;
      else if (run_dec) run_cnt <= run_cnt - RUN_W'(1);
    end
  end

  assign busy        = (state != S_IDLE);
  assign ren_ext     = 1'b0;
  assign addr_ext    = {{(62-CNT_W){1'b0}}, idx, 2'b00};
  assign addr_ext_2  = {{(61-CNT_W){1'b0}}, idx, 3'b000};
  assign wdata_ext   = sr_q[63:32];
  assign wdata_ext_2 = sr_q;

endmodule
